// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg : shared types and width helpers for the PDM-to-PCM CIC decimator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COMB = 2'd1,
        S_EMIT = 2'd2
    } cic_state_e;

    // Accumulator width: full CIC bit growth plus sign plus one guard bit.
    function automatic int cic_acc_w(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

    // Right shift taking the clamped comb output down to the PCM width.
    function automatic int cic_pcm_shift(input int order, input int decim, input int pcm_w);
        return order * $clog2(decim) + 1 - pcm_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_integrator_bank.sv
// ---------------------------------------------------------------------------
// cic_integrator_bank : cascaded strobe-enabled wrapping integrators
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic_integrator_bank #(
    parameter int ORDER = 3,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    bit_i,
    output logic signed [ACC_W-1:0] last_next_o
);

    logic signed [ACC_W-1:0] step_w;

    assign step_w = bit_i ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

    // Each stage adds the freshly updated value of the stage before it, so the
    // last stage already includes the current input bit.
    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_d;
        logic signed [ACC_W-1:0] in_w;

        if (k == 0) begin : g_first
            assign in_w = step_w;
        end else begin : g_chain
            assign in_w = g_stage[k-1].acc_d;
        end

        assign acc_d = acc_q + in_w;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (en_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign last_next_o = g_stage[ORDER-1].acc_d;

endmodule

`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_cic_decimator : PDM bitstream to signed PCM via an N-stage CIC filter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int CIC_ORDER = 3,
    parameter int DECIM     = 64,
    parameter int PCM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mic_data,
    input  logic             m_clk_rising,
    output logic [PCM_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int LOG2_D    = $clog2(DECIM);
    localparam int ACC_W     = cic_acc_w(CIC_ORDER, DECIM);
    localparam int PCM_SHIFT = cic_pcm_shift(CIC_ORDER, DECIM, PCM_W);
    localparam int K_W       = (CIC_ORDER > 1) ? $clog2(CIC_ORDER) : 1;
    localparam int WARM_W    = $clog2(CIC_ORDER + 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = {2'b01, {(ACC_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_TOP = {2'b00, {(ACC_W-2){1'b1}}};

    logic                    sync1_q;
    logic                    sync2_q;
    logic [LOG2_D-1:0]       dec_cnt_q;
    logic                    snap_w;
    logic signed [ACC_W-1:0] integ_last_w;

    cic_state_e              state_q;
    cic_state_e              state_d;
    logic [K_W-1:0]          k_q;
    logic [K_W-1:0]          k_d;
    logic signed [ACC_W-1:0] comb_x_q;
    logic signed [ACC_W-1:0] comb_x_d;
    logic signed [ACC_W-1:0] comb_dly_q [CIC_ORDER];
    logic                    emit_w;

    logic [WARM_W-1:0]       warm_q;
    logic                    warm_done_w;
    logic signed [ACC_W-1:0] y_clamp_w;
    logic [PCM_W-1:0]        sample_w;
    logic                    load_w;
    logic                    drop_w;

    logic [PCM_W-1:0]        pcm_data_q;
    logic                    pcm_valid_q;
    logic                    overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mic_data;
            sync2_q <= sync1_q;
        end
    end

    // DECIM is a power of two, so the counter wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q <= '0;
        end else if (m_clk_rising) begin
            dec_cnt_q <= dec_cnt_q + 1'b1;
        end
    end

    assign snap_w = m_clk_rising && (dec_cnt_q == LOG2_D'(DECIM - 1));

    cic_integrator_bank #(
        .ORDER (CIC_ORDER),
        .ACC_W (ACC_W)
    ) u_integ (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (m_clk_rising),
        .bit_i       (sync2_q),
        .last_next_o (integ_last_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            comb_x_q <= '0;
            for (int i = 0; i < CIC_ORDER; i++) begin
                comb_dly_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            comb_x_q <= comb_x_d;
            if (state_q == S_COMB) begin
                comb_dly_q[k_q] <= comb_x_q;
            end
        end
    end

    // One comb stage per cycle, the running value is overwritten in place.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        comb_x_d = comb_x_q;
        emit_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (snap_w) begin
                    comb_x_d = integ_last_w;
                    k_d      = '0;
                    state_d  = S_COMB;
                end
            end
            S_COMB: begin
                comb_x_d = comb_x_q - comb_dly_q[k_q];
                k_d      = k_q + 1'b1;
                if (k_q == K_W'(CIC_ORDER - 1)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                emit_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Full-scale positive is one code beyond the PCM range; pull it back in.
    assign y_clamp_w = (comb_x_q == Y_MAX) ? Y_TOP : comb_x_q;
    assign sample_w  = y_clamp_w[PCM_SHIFT +: PCM_W];

    if (PCM_SHIFT > 0) begin : g_drop_lsbs
        logic unused_bits_w;
        assign unused_bits_w = ^{y_clamp_w[ACC_W-1], y_clamp_w[PCM_SHIFT-1:0]};
    end else begin : g_keep_lsbs
        logic unused_bits_w;
        assign unused_bits_w = y_clamp_w[ACC_W-1];
    end

    assign warm_done_w = (warm_q == WARM_W'(CIC_ORDER));
    assign load_w      = emit_w && warm_done_w && (!pcm_valid_q || pcm_ready);
    assign drop_w      = emit_w && warm_done_w && pcm_valid_q && !pcm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
        end else if (emit_w && !warm_done_w) begin
            warm_q <= warm_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
        end else if (load_w) begin
            pcm_data_q  <= sample_w;
            pcm_valid_q <= 1'b1;
        end else if (pcm_valid_q && pcm_ready) begin
            pcm_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop_w) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_cic_decimator : scoreboard bench with a convolution reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pdm_cic_decimator;
    import pdm_pkg::*;

    localparam int ORDER = 3;
    localparam int D     = 64;
    localparam int PW    = 16;
    localparam int HLEN  = ORDER * (D - 1) + 1;
    localparam int SHIFT = ORDER * $clog2(D) + 1 - PW;
    localparam longint YMAX = longint'(1) << (ORDER * $clog2(D));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mic_data = 1'b0;
    logic          m_clk_rising = 1'b0;
    logic [PW-1:0] pcm_data;
    logic          pcm_valid;
    logic          pcm_ready = 1'b1;
    logic          overrun;
    logic          overrun_clr = 1'b0;

    always #5 clk = ~clk;

    pdm_cic_decimator #(
        .CIC_ORDER (ORDER),
        .DECIM     (D),
        .PCM_W     (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mic_data     (mic_data),
        .m_clk_rising (m_clk_rising),
        .pcm_data     (pcm_data),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ready modes: 0 always high, 1 held low, 2 random, 3 single pulse at pulse_at
    int rmode = 0;
    int pulse_at = -100;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                1:       pcm_ready = 1'b0;
                2:       pcm_ready = ($urandom_range(3) != 0);
                3:       pcm_ready = (cyc == pulse_at);
                default: pcm_ready = 1'b1;
            endcase
        end
    end

    // Reference model: output = zero-state convolution of the +/-1 bit history
    // with the CIC impulse response (box of length D convolved ORDER times).
    typedef struct {
        logic [PW-1:0] data;
        int            snap;
    } exp_t;

    int     h [HLEN];
    int     hist [$];
    int     warm = 0;
    bit     exp_ovr = 1'b0;
    exp_t   expq [$];
    int     snap_cyc = 0;
    logic [PW-1:0] last_acc = '0;

    function automatic logic [PW-1:0] model_sample();
        longint y = 0;
        int n = hist.size();
        for (int i = 0; i < HLEN && i < n; i++) y += longint'(h[i]) * hist[n-1-i];
        if (y == YMAX) y = YMAX - 1;
        y = y >>> SHIFT;
        return PW'(y);
    endfunction

    task automatic send_bit(input bit b);
        bit   snap_now;
        exp_t e;
        @(negedge clk);
        mic_data = b;
        repeat (2) @(negedge clk);
        snap_now = (hist.size() % D == D - 1);
        if (snap_now) check("fsm_idle_at_snapshot", dut.state_q, S_IDLE);
        m_clk_rising = 1'b1;
        @(negedge clk);
        m_clk_rising = 1'b0;
        hist.push_back(b ? 1 : -1);
        if (snap_now) begin
            snap_cyc = cyc;
            if (warm < ORDER) begin
                warm++;
            end else if (rmode == 1 && expq.size() > 0) begin
                exp_ovr = 1'b1;
            end else begin
                e.data = model_sample();
                e.snap = snap_cyc;
                expq.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, expq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: latency on each fresh valid, data compare on each accept.
    logic prev_valid = 1'b0;
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pcm_valid && !prev_valid) begin
                    if (expq.size() == 0) check("valid_without_expected", pcm_valid, 0);
                    else check("valid_latency", cyc - expq[0].snap, ORDER + 1);
                end
                if (pcm_valid && pcm_ready) begin
                    if (expq.size() == 0) begin
                        check("accept_without_expected", pcm_valid, 0);
                    end else begin
                        ex = expq.pop_front();
                        check("pcm_data", pcm_data, ex.data);
                        last_acc = pcm_data;
                    end
                end
            end
            prev_valid = pcm_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t [HLEN];
        for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
        for (int s = 0; s < ORDER; s++) begin
            for (int i = 0; i < HLEN; i++) begin
                t[i] = 0;
                for (int j = 0; j < D && j <= i; j++) t[i] += h[i-j];
            end
            h = t;
        end

        repeat (3) @(negedge clk);
        check("reset_valid", pcm_valid, 0);
        check("reset_data", pcm_data, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;

        repeat (7 * D) send_bit(1'b1);
        drain("drain_ones");
        check("ones_value", last_acc, 16'h7FFF);

        repeat (7 * D) send_bit(1'b0);
        drain("drain_zeros");
        check("zeros_value", last_acc, 16'h8000);

        for (int i = 0; i < 7 * D; i++) send_bit(i[0] == 1'b0);
        drain("drain_alt");
        check("alt_value", last_acc, 16'h0000);

        rmode = 2;
        repeat (8 * D) send_bit(1'($urandom_range(1)));
        rmode = 0;
        drain("drain_random");
        check("random_no_overrun", overrun, exp_ovr);

        // Backpressure across two decimation events.
        rmode = 1;
        repeat (2) @(negedge clk);
        repeat (2 * D) send_bit(1'($urandom_range(1)));
        repeat (8) @(negedge clk);
        check("bp_valid_held", pcm_valid, 1);
        check("bp_data_held", pcm_data, expq[0].data);
        check("bp_overrun_set", overrun, exp_ovr);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        check("bp_overrun_clr", overrun, exp_ovr);
        check("bp_valid_after_clr", pcm_valid, 1);
        rmode = 0;
        drain("drain_bp");
        check("bp_valid_drained", pcm_valid, 0);

        // Accept of the old sample in the same cycle the new one loads.
        rmode = 1;
        repeat (2) @(negedge clk);
        repeat (2 * D - 1) send_bit(1'($urandom_range(1)));
        pulse_at = -100;
        rmode = 3;
        send_bit(1'($urandom_range(1)));
        pulse_at = snap_cyc + ORDER;
        repeat (ORDER + 2) @(negedge clk);
        check("swap_valid_kept", pcm_valid, 1);
        check("swap_new_data", pcm_data, expq[0].data);
        check("swap_no_overrun", overrun, exp_ovr);
        rmode = 0;
        drain("drain_swap");

        // Reset while the comb pipeline is busy, with a pending sample and overrun.
        rmode = 1;
        repeat (2) @(negedge clk);
        repeat (3 * D) send_bit(1'($urandom_range(1)));
        check("pre_reset_overrun", overrun, exp_ovr);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", pcm_valid, 0);
        check("midrst_data", pcm_data, 0);
        check("midrst_overrun", overrun, 0);
        hist.delete();
        expq.delete();
        warm = 0;
        exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 0;
        repeat (6 * D) send_bit(1'b1);
        drain("drain_after_reset");
        check("after_reset_value", last_acc, 16'h7FFF);
        check("after_reset_overrun", overrun, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
